// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the Bitcoin hash top and its downstream stages.
package bitcoin_pkg;

  localparam int unsigned NUM_NONCES_DEFAULT = 16;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned ADDR_W             = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam word_t H0_INIT_BEST = 32'hFFFF_FFFF;

endpackage : bitcoin_pkg

// File: rtl/scan_accumulator.sv
// Per-capture target compare and running minimum over the scanned H0 words.
module scan_accumulator
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int unsigned NONCE_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  cap_valid_i,
  input  logic [NONCE_W-1:0]    idx_i,
  input  word_t                 word_i,
  input  word_t                 target_i,
  output logic                  found_o,
  output logic [NUM_NONCES-1:0] match_mask_o,
  output logic [NONCE_W-1:0]    match_count_o,
  output logic [NONCE_W-1:0]    best_nonce_o,
  output word_t                 best_hash_o
);

  logic                  found_q, found_d;
  logic [NUM_NONCES-1:0] mask_q, mask_d;
  logic [NONCE_W-1:0]    count_q, count_d;
  logic [NONCE_W-1:0]    nonce_q, nonce_d;
  word_t                 best_q, best_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      nonce_q <= '0;
      best_q  <= H0_INIT_BEST;
    end else begin
      found_q <= found_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      nonce_q <= nonce_d;
      best_q  <= best_d;
    end
  end

  // Strict less-than on the minimum keeps the lowest nonce on ties.
  always_comb begin
    found_d = found_q;
    mask_d  = mask_q;
    count_d = count_q;
    nonce_d = nonce_q;
    best_d  = best_q;
    if (clear_i) begin
      found_d = 1'b0;
      mask_d  = '0;
      count_d = '0;
      nonce_d = '0;
      best_d  = H0_INIT_BEST;
    end else if (cap_valid_i) begin
      if (word_i < target_i) begin
        found_d = 1'b1;
        mask_d  = mask_q | (NUM_NONCES'(1) << idx_i);
        count_d = count_q + NONCE_W'(1);
      end
      if (word_i < best_q) begin
        best_d  = word_i;
        nonce_d = idx_i;
      end
    end
  end

  assign found_o       = found_q;
  assign match_mask_o  = mask_q;
  assign match_count_o = count_q;
  assign best_nonce_o  = nonce_q;
  assign best_hash_o   = best_q;

endmodule : scan_accumulator

// File: rtl/nonce_result_scan.sv
// Reads back NUM_NONCES H0 result words over the shared memory port and
// reports target matches plus the minimum word and its nonce.
module nonce_result_scan
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int unsigned NONCE_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     result_addr,
  input  word_t                 target,
  output logic                  done,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output word_t                 mem_write_data,
  input  word_t                 mem_read_data,
  output logic                  found,
  output logic [NUM_NONCES-1:0] match_mask,
  output logic [NONCE_W-1:0]    match_count,
  output logic [NONCE_W-1:0]    best_nonce,
  output word_t                 best_hash
);

  state_e              state_q, state_d;
  logic [NONCE_W-1:0]  issue_q, issue_d;
  logic [NONCE_W-1:0]  cap_q, cap_d;
  logic                armed_q, armed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  word_t               target_q, target_d;
  logic                clear;
  logic                cap_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      issue_q  <= '0;
      cap_q    <= '0;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      issue_q  <= issue_d;
      cap_q    <= cap_d;
      armed_q  <= armed_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      target_q <= target_d;
    end
  end

  // armed_q marks that the first read is two edges deep and data is valid.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    armed_d   = armed_q;
    addr_d    = addr_q;
    base_d    = base_q;
    target_d  = target_q;
    clear     = 1'b0;
    cap_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = result_addr;
          base_d   = result_addr;
          issue_d  = NONCE_W'(1);
          cap_d    = '0;
          armed_d  = 1'b0;
          target_d = target;
          clear    = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (issue_q < NONCE_W'(NUM_NONCES)) begin
          addr_d  = base_q + ADDR_W'(issue_q);
          issue_d = issue_q + NONCE_W'(1);
        end
        if (armed_q) begin
          cap_valid = 1'b1;
          cap_d     = cap_q + NONCE_W'(1);
          if (cap_q == NONCE_W'(NUM_NONCES - 1)) begin
            state_d = IDLE;
            armed_d = 1'b0;
          end
        end else begin
          armed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  scan_accumulator #(
    .NUM_NONCES (NUM_NONCES),
    .NONCE_W    (NONCE_W)
  ) u_acc (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_i       (clear),
    .cap_valid_i   (cap_valid),
    .idx_i         (cap_q),
    .word_i        (mem_read_data),
    .target_i      (target_q),
    .found_o       (found),
    .match_mask_o  (match_mask),
    .match_count_o (match_count),
    .best_nonce_o  (best_nonce),
    .best_hash_o   (best_hash)
  );

  assign done           = (state_q == IDLE);
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_addr       = addr_q;
  assign mem_write_data = '0;

endmodule : nonce_result_scan

// File: tb/tb_nonce_result_scan.sv
// Scoreboard bench for nonce_result_scan with a synchronous-read memory model.
module tb_nonce_result_scan;

  localparam int unsigned N  = 16;
  localparam int unsigned NW = 8;

  typedef struct {
    logic          found;
    logic [N-1:0]  mask;
    logic [NW-1:0] count;
    logic [NW-1:0] nonce;
    logic [31:0]   hash;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   result_addr = '0;
  logic [31:0]   target = '0;
  logic          done, mem_clk, mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data = '0;
  logic          found;
  logic [N-1:0]  match_mask;
  logic [NW-1:0] match_count, best_nonce;
  logic [31:0]   best_hash;

  logic [31:0]   mem [0:65535];
  exp_t          exp_q[$];
  logic [15:0]   addr_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  nonce_result_scan #(.NUM_NONCES(N), .NONCE_W(NW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .found          (found),
    .match_mask     (match_mask),
    .match_count    (match_count),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem[mem_addr];

  // Reference model: expected results from the preloaded memory image.
  task automatic push_expected(input logic [15:0] base, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] w;
    e.found = 1'b0; e.mask = '0; e.count = '0; e.nonce = '0; e.hash = 32'hFFFF_FFFF;
    for (int n = 0; n < N; n++) begin
      w = mem[16'(base + 16'(n))];
      if (w < tgt) begin
        e.found = 1'b1; e.mask[n] = 1'b1; e.count = e.count + 8'd1;
      end
      if (w < e.hash) begin
        e.hash = w; e.nonce = NW'(n);
      end
      addr_q.push_back(16'(base + 16'(n)));
    end
    exp_q.push_back(e);
  endtask

  // Drive one scan and check the address stream, done window and results.
  task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt,
                          input bit hold, input bit disturb);
    exp_t e;
    logic [15:0] ea;
    int cycles;
    push_expected(base, tgt);
    @(negedge clk);
    result_addr = base; target = tgt; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cycles = 0;
    while (done === 1'b0 && cycles < 100) begin
      if (cycles < N) begin
        ea = addr_q.pop_front();
        if (mem_addr !== ea) begin
          n_err++; $display("FAIL mem_addr cyc %0d: got %h want %h", cycles, mem_addr, ea);
        end
        n_cmp++;
      end
      if (mem_we !== 1'b0) begin
        n_err++; $display("FAIL mem_we cyc %0d: got %b want 0", cycles, mem_we);
      end
      n_cmp++;
      if (disturb) begin
        start = (cycles == 5);
        if (cycles == 3) begin target = ~tgt; result_addr = base ^ 16'h5555; end
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (disturb) start = 1'b0;
    if (cycles != N + 1) begin
      n_err++; $display("FAIL done_low_cycles: got %0d want %0d", cycles, N + 1);
    end
    n_cmp++;
    e = exp_q.pop_front();
    if (found !== e.found) begin
      n_err++; $display("FAIL found: got %b want %b", found, e.found);
    end
    n_cmp++;
    if (match_mask !== e.mask) begin
      n_err++; $display("FAIL match_mask: got %h want %h", match_mask, e.mask);
    end
    n_cmp++;
    if (match_count !== e.count) begin
      n_err++; $display("FAIL match_count: got %0d want %0d", match_count, e.count);
    end
    n_cmp++;
    if (best_nonce !== e.nonce) begin
      n_err++; $display("FAIL best_nonce: got %0d want %0d", best_nonce, e.nonce);
    end
    n_cmp++;
    if (best_hash !== e.hash) begin
      n_err++; $display("FAIL best_hash: got %h want %h", best_hash, e.hash);
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    if (done !== 1'b1)              begin n_err++; $display("FAIL rst_done: got %b want 1", done); end
    if (mem_addr !== 16'h0)         begin n_err++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    if (found !== 1'b0)             begin n_err++; $display("FAIL rst_found: got %b want 0", found); end
    if (match_mask !== '0)          begin n_err++; $display("FAIL rst_mask: got %h want 0", match_mask); end
    if (match_count !== '0)         begin n_err++; $display("FAIL rst_count: got %0d want 0", match_count); end
    if (best_nonce !== '0)          begin n_err++; $display("FAIL rst_nonce: got %0d want 0", best_nonce); end
    if (best_hash !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_hash: got %h want ffffffff", best_hash); end
    if (mem_we !== 1'b0 || mem_write_data !== 32'h0) begin
      n_err++; $display("FAIL rst_mem_wr: got we=%b wd=%h want 0/0", mem_we, mem_write_data);
    end
    n_cmp += 8;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_ascending();
    for (int n = 0; n < N; n++) mem[16'h0100 + n] = 32'h1000_0000 + n;
    run_scan(16'h0100, 32'h1000_0005, 1'b0, 1'b0);
  endtask

  task automatic test_single_hit();
    for (int n = 0; n < N; n++) mem[16'h0200 + n] = 32'hFFFF_FFFF;
    mem[16'h0209] = 32'h0000_0ABC;
    run_scan(16'h0200, 32'h0000_1000, 1'b0, 1'b0);
  endtask

  task automatic test_target_zero_tie();
    for (int n = 0; n < N; n++) mem[16'h0300 + n] = 32'h8000_0000;
    mem[16'h0303] = 32'h1; mem[16'h030C] = 32'h1;
    run_scan(16'h0300, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_all_ones();
    for (int n = 0; n < N; n++) mem[16'h0400 + n] = 32'hFFFF_FFFF;
    run_scan(16'h0400, 32'hFFFF_FFFF, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < N; n++) mem[16'(16'hFFF8 + 16'(n))] = $urandom;
    run_scan(16'hFFF8, 32'h8000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    for (int n = 0; n < N; n++) mem[16'h0500 + n] = 32'h0000_0010;
    @(negedge clk);
    result_addr = 16'h0500; target = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1; reset_n = 1'b0; #1;
    if (done !== 1'b1 || mem_addr !== 16'h0 || match_count !== '0 || best_hash !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL mid_reset: got done=%b addr=%h cnt=%0d hash=%h want 1/0000/0/ffffffff",
                        done, mem_addr, match_count, best_hash);
    end
    n_cmp++;
    @(negedge clk); reset_n = 1'b1;
    for (int n = 0; n < N; n++) mem[16'h0500 + n] = 32'h2000_0000 - 32'(n);
    run_scan(16'h0500, 32'h1FFF_FFFA, 1'b0, 1'b0);
  endtask

  task automatic test_disturb();
    for (int n = 0; n < N; n++) mem[16'h0600 + n] = $urandom;
    run_scan(16'h0600, 32'h6000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < N; n++) mem[16'h0700 + n] = $urandom;
    run_scan(16'h0700, 32'h4000_0000, 1'b1, 1'b0);
    for (int n = 0; n < N; n++) mem[16'h0800 + n] = $urandom;
    run_scan(16'h0800, 32'hC000_0000, 1'b1, 1'b0);
    start = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 32'(a) * 32'h9E37_79B9;
    test_reset();
    test_ascending();
    test_single_hit();
    test_target_zero_tie();
    test_all_ones();
    test_wrap();
    test_reset_mid_scan();
    test_disturb();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nonce_result_scan

// File: doc/nonce_result_scan.md
Name: nonce_result_scan

Overview:
- Downstream stage of the Bitcoin hash top. It runs after the hash core has written one final H0 word per nonce into shared memory at output_addr.
- It reads those NUM_NONCES words back over the same single-port memory interface and compares each word against a difficulty target.
- It reports which nonces meet the target, plus the nonce with the numerically smallest H0 and that H0 value.
- It uses the same start/done handshake and memory protocol as the hash core, so the top-level sequencer can chain the two blocks.

Parameters:
- NUM_NONCES, 16: number of consecutive result words to scan; legal range 1..255.
- NONCE_W, 8: width of nonce index outputs; must satisfy 2**NONCE_W > NUM_NONCES.

Ports:
- clk  input  1  clock; also drives mem_clk.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only while idle.
- result_addr  input  16  base address of the NUM_NONCES H0 words.
- target  input  32  unsigned threshold; a word qualifies iff word < target.
- done  output  1  high while idle.
- mem_clk  output  1  equals clk.
- mem_we  output  1  tied 0 (read-only block).
- mem_addr  output  16  read address.
- mem_write_data  output  32  tied 0.
- mem_read_data  input  32  synchronous-read data.
- found  output  1  at least one word qualified.
- match_mask  output  NUM_NONCES  bit n set iff word n < target.
- match_count  output  NONCE_W  number of set bits in match_mask.
- best_nonce  output  NONCE_W  index of the minimum word.
- best_hash  output  32  value of the minimum word.

Behaviour:
- Memory protocol: mem_addr is registered. The memory samples the address at the posedge after it is driven, and the block captures mem_read_data at the following posedge. Read pipeline depth is 2.
- Reset (async) values: state IDLE, done=1, mem_addr=0, found=0, match_mask=0, match_count=0, best_nonce=0, best_hash=32'hFFFFFFFF, internal issue/capture counters=0.
- States: IDLE, SCAN. done = (state==IDLE).
- IDLE, start=1 at posedge P0:
  - mem_addr<=result_addr; issue_cnt<=1; cap_cnt<=0.
  - Clear all result outputs to their reset values; latch target into target_q.
  - state<=SCAN.
  - start=0 in IDLE: hold all outputs unchanged.
- SCAN, every posedge:
  - If issue_cnt<NUM_NONCES: mem_addr<=result_addr+issue_cnt; issue_cnt++. Otherwise hold mem_addr.
  - From the second SCAN edge on, capture word=mem_read_data for index cap_cnt, then cap_cnt++.
  - Capture update: if word<target_q, set match_mask[cap_cnt], increment match_count, set found.
  - Capture update: if word<best_hash (strict), best_hash<=word and best_nonce<=cap_cnt. Ties keep the lower nonce.
  - On the capture of index NUM_NONCES-1, state<=IDLE.
- Latency: word k is captured at posedge P0+k+2. done is low for exactly NUM_NONCES+1 cycles and rises after posedge P0+NUM_NONCES+1.
  - All outputs are final and stable from that point until the next accepted start.
- Address arithmetic is 16-bit modulo; result_addr+k wraps past 16'hFFFF to 0.
- Comparisons are unsigned 32-bit. target=0 yields found=0 and match_mask=0. best_* is still computed.
- A word equal to 32'hFFFFFFFF never replaces the initial best_hash, so best_nonce stays 0 unless a smaller word appears.
- start while in SCAN is ignored. target and result_addr changes during SCAN have no effect; both are latched or used from the start edge.
- reset_n asserted mid-scan: immediate return to reset values; a subsequent start performs a complete fresh scan.
- start held high continuously: a new scan begins on the first posedge where state is IDLE. done pulses high for one cycle between scans.

Decomposition:
- Shared package bitcoin_pkg holds:
  - NUM_NONCES default
  - state enum type {IDLE, SCAN}
  - 32-bit word typedef
  - H0_INIT_BEST constant 32'hFFFFFFFF
- One natural sub-module: scan_accumulator.
  - Combinational compare plus registered update of match_mask, match_count, found, best_nonce and best_hash.
  - Driven by capture-valid, index and word inputs from the top-level FSM.

Test Plan:
- Words 0..15 = 32'h10000000+n, target=32'h10000005, result_addr=16'h0100 -> match_mask=16'h001F, match_count=5, found=1, best_nonce=0, best_hash=32'h10000000; mem_addr sequence 0x0100..0x010F; done low 17 cycles.
- Words all 32'hFFFFFFFF except word 9=32'h00000ABC, target=32'h00001000 -> match_mask=16'h0200, match_count=1, best_nonce=9, best_hash=32'h00000ABC.
- Words 3 and 12 both 32'h00000001, all others 32'h80000000, target=0 -> found=0, match_mask=0, best_nonce=3, best_hash=1.
- result_addr=16'hFFF8 -> mem_addr sequence wraps 0xFFF8..0xFFFF then 0x0000..0x0007; captured data matches the preloaded words at the wrapped addresses.
- Assert reset_n for one cycle at capture of index 6, then start again with new contents -> outputs reflect only the second scan; mem_we stays 0 throughout.
- Pulse start during SCAN and toggle target mid-scan -> no restart; results use the target latched at start.
